// File: rtl/fp_booth_seq_mul.sv
// Sequential radix-4 Booth multiplier for binary32 significands: one Booth digit
// per cycle into a 50-bit two's-complement accumulator, valid/ready on both sides.
module fp_booth_seq_mul #(
  parameter int N_DIGITS = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  input  logic [2:0]  r_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] frc_Z_full,
  output logic        sign_Z,
  output logic [2:0]  r_mode_o,
  output logic        flush_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [23:0] m;
  logic [25:0] q;
  logic [49:0] acc;
  logic [3:0]  cnt;

  logic        x_sub, x_nif, y_sub, y_nif, flush_in;
  logic [26:0] q_ext;
  logic [4:0]  shamt;
  logic [2:0]  triplet;
  logic [49:0] m_ext;
  logic [49:0] pp;
  logic [49:0] acc_sum;
  logic        last_digit;

  assign x_sub    = (fp_X[30:23] == 8'h00);
  assign x_nif    = (fp_X[30:23] == 8'hFF);
  assign y_sub    = (fp_Y[30:23] == 8'h00);
  assign y_nif    = (fp_Y[30:23] == 8'hFF);
  assign flush_in = (x_sub && !y_nif) || (y_sub && !x_nif);

  // Q[-1] = 0 is supplied by the appended zero, so digit i reads q_ext[2i+2:2i].
  assign q_ext      = {q, 1'b0};
  assign shamt      = {cnt, 1'b0};
  assign triplet    = q_ext[shamt +: 3];
  assign m_ext      = {26'd0, m};
  assign last_digit = (cnt == 4'(N_DIGITS - 1));

  always_comb begin
    pp = 50'd0;
    case (triplet)
      3'b001, 3'b010: pp = m_ext;
      3'b011:         pp = m_ext << 1;
      3'b100:         pp = -(m_ext << 1);
      3'b101, 3'b110: pp = -m_ext;
      default:        pp = 50'd0;
    endcase
  end

  assign acc_sum = acc + (pp << shamt);

  // Reset overrides ready so nothing can look acceptable while rst is held.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = flush_in ? DONE : BUSY;
      BUSY: if (last_digit) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      m          <= 24'd0;
      q          <= 26'd0;
      acc        <= 50'd0;
      cnt        <= 4'd0;
      frc_Z_full <= 48'd0;
      sign_Z     <= 1'b0;
      r_mode_o   <= 3'd0;
      flush_o    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            m        <= {1'b1, fp_X[22:0]};
            q        <= {2'b00, 1'b1, fp_Y[22:0]};
            sign_Z   <= fp_X[31] ^ fp_Y[31];
            r_mode_o <= r_mode;
            flush_o  <= flush_in;
            acc      <= 50'd0;
            cnt      <= 4'd0;
            if (flush_in) frc_Z_full <= 48'd0;
          end
        end
        BUSY: begin
          acc <= acc_sum;
          cnt <= cnt + 4'd1;
          if (last_digit) frc_Z_full <= acc_sum[47:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_booth_seq_mul.sv
// Randomized and directed bench for fp_booth_seq_mul against a plain-arithmetic
// product model; inputs driven and outputs sampled on the falling edge.
module tb_fp_booth_seq_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp_X;
  logic [31:0] fp_Y;
  logic [2:0]  r_mode;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] frc_Z_full;
  logic        sign_Z;
  logic [2:0]  r_mode_o;
  logic        flush_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_booth_seq_mul #(.N_DIGITS(13)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .fp_X(fp_X), .fp_Y(fp_Y), .r_mode(r_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .frc_Z_full(frc_Z_full), .sign_Z(sign_Z),
    .r_mode_o(r_mode_o), .flush_o(flush_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_flush(input logic [31:0] x, input logic [31:0] y);
    bit xs, xn, ys, yn;
    xs = (x[30:23] == 8'h00);
    xn = (x[30:23] == 8'hFF);
    ys = (y[30:23] == 8'h00);
    yn = (y[30:23] == 8'hFF);
    return (xs && !yn) || (ys && !xn);
  endfunction

  function automatic logic [47:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
    logic [47:0] a, b;
    if (ref_flush(x, y)) return 48'd0;
    a = {24'd0, 1'b1, x[22:0]};
    b = {24'd0, 1'b1, y[22:0]};
    return a * b;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 4))
      0: v[30:23] = 8'h00;
      1: v[30:23] = 8'hFF;
      default: ;
    endcase
    return v;
  endfunction

  task automatic garbage();
    in_valid = 1'($urandom);
    fp_X     = $urandom;
    fp_Y     = $urandom;
    r_mode   = 3'($urandom);
  endtask

  // Entered at a falling edge; leaves at the falling edge right after the release.
  task automatic run_txn(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm,
                         input int hold, input string name);
    int          w;
    int          lat;
    int          exp_lat;
    logic [47:0] held;
    in_valid = 1'b1;
    fp_X     = x;
    fp_Y     = y;
    r_mode   = rm;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_eq({name, "/ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    check_eq({name, "/ready_after_accept"}, 64'(in_ready), 64'd0);
    garbage();
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      garbage();
    end
    exp_lat = ref_flush(x, y) ? 1 : 14;
    check_eq({name, "/latency"}, 64'(lat), 64'(exp_lat));
    check_eq({name, "/frc"}, 64'(frc_Z_full), 64'(ref_prod(x, y)));
    check_eq({name, "/sign"}, 64'(sign_Z), 64'(x[31] ^ y[31]));
    check_eq({name, "/rmode"}, 64'(r_mode_o), 64'(rm));
    check_eq({name, "/flush"}, 64'(flush_o), 64'(ref_flush(x, y)));
    $display("txn %s: X=%08h Y=%08h rm=%0d -> frc=%012h sign=%0d flush=%0d lat=%0d",
             name, x, y, rm, frc_Z_full, sign_Z, flush_o, lat);
    held = ref_prod(x, y);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      garbage();
      check_eq({name, "/hold_valid"}, 64'(out_valid), 64'd1);
      check_eq({name, "/hold_frc"}, 64'(frc_Z_full), 64'(held));
      check_eq({name, "/hold_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_eq({name, "/release_valid"}, 64'(out_valid), 64'd0);
    check_eq({name, "/release_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int spurious;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    fp_X      = 32'd0;
    fp_Y      = 32'd0;
    r_mode    = 3'd0;
    repeat (3) @(negedge clk);
    check_eq("rst/in_ready", 64'(in_ready), 64'd0);
    check_eq("rst/out_valid", 64'(out_valid), 64'd0);
    check_eq("rst/frc", 64'(frc_Z_full), 64'd0);
    check_eq("rst/sign", 64'(sign_Z), 64'd0);
    check_eq("rst/rmode", 64'(r_mode_o), 64'd0);
    check_eq("rst/flush", 64'(flush_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst/in_ready", 64'(in_ready), 64'd1);

    run_txn(32'h40400000, 32'h40400000, 3'b001, 0, "3x3");
    run_txn(32'h3F800000, 32'hBF800000, 3'b010, 0, "1xm1");
    run_txn(32'h3FFFFFFF, 32'h3FFFFFFF, 3'b011, 0, "maxsig");
    run_txn(32'h00000001, 32'h3F800000, 3'b100, 0, "flush");
    run_txn(32'h00000001, 32'h7F800000, 3'b101, 0, "sub_x_inf");
    run_txn(32'hC0400000, 32'h40400000, 3'b110, 5, "backpressure");
    run_txn(32'h3FC00000, 32'h40A00000, 3'b111, 0, "back_to_back");

    // Reset during the sixth BUSY cycle.
    in_valid = 1'b1;
    fp_X     = 32'h40400000;
    fp_Y     = 32'h40400000;
    r_mode   = 3'b001;
    @(posedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("mid_rst/out_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst/in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("mid_rst/idle", 64'(in_ready), 64'd1);
    spurious = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    check_eq("mid_rst/no_stale", 64'(spurious), 64'd0);
    run_txn(32'h40400000, 32'h40400000, 3'b001, 0, "3x3_after_rst");

    // Reset and handshake on the same edge: transaction must be dropped.
    in_valid = 1'b1;
    rst      = 1'b1;
    fp_X     = 32'h3F800000;
    fp_Y     = 32'h3F800000;
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    spurious = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    check_eq("rst_vs_accept/dropped", 64'(spurious), 64'd0);

    for (int t = 0; t < 40; t++) begin
      run_txn(rand_op(), rand_op(), 3'($urandom), $urandom_range(0, 3), $sformatf("rnd%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
